// File: rtl/cas_pkg.sv
// -----------------------------------------------------------------------------
// cas_pkg
// Shared definitions for the cassette image loader: bus widths, the loader
// FSM state encoding and the SVI cassette header constants (16 lead bytes of
// 8'h55 followed by one sync byte of 8'h7F).
// No ports (package).
// -----------------------------------------------------------------------------
package cas_pkg;

  localparam int IOCTL_AW = 18;
  localparam int SDRAM_AW = 25;

  localparam logic [7:0] SVI_LEAD_BYTE = 8'h55;
  localparam logic [7:0] SVI_SYNC_BYTE = 8'h7F;
  localparam int         SVI_LEAD_LEN  = 16;

  // Header = lead bytes plus the single sync byte.
  localparam int HDR_LEN = SVI_LEAD_LEN + 1;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } cas_state_t;

  // Expected header byte at a given image offset (valid for offsets < HDR_LEN).
  function automatic logic [7:0] hdr_expect(input logic [IOCTL_AW-1:0] off);
    return (off < IOCTL_AW'(SVI_LEAD_LEN)) ? SVI_LEAD_BYTE : SVI_SYNC_BYTE;
  endfunction

endpackage

// File: rtl/cas_loader_if.sv
// -----------------------------------------------------------------------------
// cas_loader_if
// Bundles the host download (ioctl_*) signals and the toggle-handshake SDRAM
// write port (sdram_*) used by cas_loader.
//   slave  : the loader side (consumes ioctl writes, issues SDRAM writes)
//   master : the environment side (host + SDRAM controller)
// -----------------------------------------------------------------------------
interface cas_loader_if;
  import cas_pkg::*;

  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic                ioctl_wait;

  logic [SDRAM_AW-1:0] sdram_addr;
  logic [7:0]          sdram_data;
  logic                sdram_wr;
  logic                sdram_ack;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  sdram_ack,
    output ioctl_wait, sdram_addr, sdram_data, sdram_wr
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output sdram_ack,
    input  ioctl_wait, sdram_addr, sdram_data, sdram_wr
  );

endinterface

// File: rtl/cas_hdr_check.sv
// -----------------------------------------------------------------------------
// cas_hdr_check
// Tracks whether the cassette header (offsets 0x00..0x10) has been written
// with the expected lead/sync bytes. One mask bit per header offset; a write
// to that offset sets the bit on a match and clears it on a mismatch, so a
// rewritten bad byte correctly invalidates the header.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : start of a new download; empties the mask (same-cycle wr
//                  is still applied on top of the cleared mask)
//   wr           : accepted image write strobe
//   addr, data   : image offset and byte of the write
//   ok           : all header offsets have matched
// -----------------------------------------------------------------------------
module cas_hdr_check
  import cas_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                wr,
  input  logic [IOCTL_AW-1:0] addr,
  input  logic [7:0]          data,
  output logic                ok
);

  logic [HDR_LEN-1:0] mask_q;
  logic [HDR_LEN-1:0] mask_d;

  always_comb begin
    mask_d = clear ? '0 : mask_q;
    if (wr && (addr < IOCTL_AW'(HDR_LEN))) begin
      mask_d[addr[4:0]] = (data == hdr_expect(addr));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign ok = &mask_q;

endmodule

// File: rtl/cas_loader.sv
// -----------------------------------------------------------------------------
// cas_loader
// Copies a host-downloaded cassette image into SDRAM one byte at a time over
// a toggle request/acknowledge port, tracks the image length, validates the
// SVI header and raises 'loaded' once the download has ended and the last
// SDRAM write has been flushed.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus          : cas_loader_if.slave (ioctl_* download, sdram_* write port)
//   end_addr     : image length in bytes (highest written offset + 1, sat.)
//   loaded       : image complete, non-empty and written without overrun
//   status       : {overrun, header_ok, busy}
// -----------------------------------------------------------------------------
module cas_loader
  import cas_pkg::*;
#(
  parameter logic [7:0]          CAS_INDEX = 8'h01,
  parameter logic [SDRAM_AW-1:0] BASE_ADDR = 25'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  cas_loader_if.slave         bus,
  output logic [IOCTL_AW-1:0] end_addr,
  output logic                loaded,
  output logic [2:0]          status
);

  cas_state_t          state, next_state;
  logic                active, active_q;
  logic                start, fall;
  logic                capture, toggle, wait_c, drop;
  logic                overrun_q, overrun_d;
  logic                loaded_q, finishing_q;
  logic                hdr_ok;
  logic [IOCTL_AW-1:0] end_addr_q, end_addr_d, end_base, addr_inc;
  logic [SDRAM_AW-1:0] sdram_addr_q;
  logic [7:0]          sdram_data_q;
  logic                sdram_wr_q;

  // Offset + 1, held at the top of the 18-bit range instead of wrapping.
  function automatic logic [IOCTL_AW-1:0] sat_inc(input logic [IOCTL_AW-1:0] a);
    return (&a) ? a : a + IOCTL_AW'(1);
  endfunction

  assign active = bus.ioctl_download && (bus.ioctl_index == CAS_INDEX);
  assign start  = active && !active_q;
  assign fall   = !active && active_q;

  // FSM next-state and handshake outputs
  always_comb begin
    next_state = state;
    wait_c     = 1'b1;
    capture    = 1'b0;
    toggle     = 1'b0;
    case (state)
      SYNC: next_state = IDLE;
      IDLE: begin
        wait_c = 1'b0;
        if (active && bus.ioctl_wr) begin
          capture    = 1'b1;
          wait_c     = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        toggle     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (bus.sdram_ack == sdram_wr_q) next_state = IDLE;
      end
      default: next_state = SYNC;
    endcase
  end

  // Any active write the FSM cannot take is lost and flagged.
  assign drop = active && bus.ioctl_wr && (state != IDLE);

  // Download start clears the flags first; a same-cycle write then lands
  // on the cleared values.
  always_comb begin
    end_base   = start ? '0 : end_addr_q;
    addr_inc   = sat_inc(bus.ioctl_addr);
    end_addr_d = end_base;
    if (capture && (addr_inc > end_base)) end_addr_d = addr_inc;
    overrun_d  = (start ? 1'b0 : overrun_q) | drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= 1'b0;
      sdram_wr_q   <= 1'b0;
      sdram_addr_q <= BASE_ADDR;
      sdram_data_q <= 8'h00;
      end_addr_q   <= '0;
      overrun_q    <= 1'b0;
      loaded_q     <= 1'b0;
      finishing_q  <= 1'b0;
    end else begin
      active_q   <= active;
      end_addr_q <= end_addr_d;
      overrun_q  <= overrun_d;

      // Align the request toggle to the controller's ack after reset so no
      // spurious write is seen as pending.
      if (state == SYNC) sdram_wr_q <= bus.sdram_ack;
      else if (toggle)   sdram_wr_q <= ~sdram_wr_q;

      if (capture) begin
        sdram_addr_q <= BASE_ADDR + SDRAM_AW'(bus.ioctl_addr);
        sdram_data_q <= bus.ioctl_dout;
      end

      // loaded is decided on the first cycle the FSM is back in IDLE after
      // the download ends, so the final pending write is flushed first.
      if (start) begin
        loaded_q    <= 1'b0;
        finishing_q <= 1'b0;
      end else if ((fall || finishing_q) && (next_state == IDLE)) begin
        loaded_q    <= (end_addr_q != '0) && !overrun_q;
        finishing_q <= 1'b0;
      end else if (fall) begin
        finishing_q <= 1'b1;
      end
    end
  end

  cas_hdr_check u_hdr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start),
    .wr      (capture),
    .addr    (bus.ioctl_addr),
    .data    (bus.ioctl_dout),
    .ok      (hdr_ok)
  );

  assign bus.ioctl_wait = wait_c;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.sdram_data = sdram_data_q;
  assign bus.sdram_wr   = sdram_wr_q;

  assign end_addr = end_addr_q;
  assign loaded   = loaded_q;
  assign status   = {overrun_q, hdr_ok, wait_c};

endmodule

// File: tb/tb_cas_loader.sv
// -----------------------------------------------------------------------------
// tb_cas_loader
// Directed bench for cas_loader. Accepted host writes push their expected
// SDRAM address/data into a queue; a monitor pops and compares on every
// sdram_wr toggle. A responder process models the SDRAM controller ack delay.
// -----------------------------------------------------------------------------
module tb_cas_loader;
  import cas_pkg::*;

  localparam logic [24:0] BASE = 25'h100000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] end_addr;
  logic        loaded;
  logic [2:0]  status;

  cas_loader_if bus();

  cas_loader #(.CAS_INDEX(8'h01), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .end_addr (end_addr),
    .loaded   (loaded),
    .status   (status)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          ack_delay = 3;
  bit          rsp_en = 1'b0;
  bit          mon_en = 1'b0;
  logic        prev_wr = 1'b0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM controller model: ack a pending toggle after ack_delay cycles.
  initial begin
    bus.sdram_ack = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_en && (bus.sdram_wr !== bus.sdram_ack)) begin
        repeat (ack_delay) @(posedge clk);
        #1;
        bus.sdram_ack = bus.sdram_wr;
      end
    end
  end

  // Monitor: every request toggle must match the oldest expected write.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.sdram_wr !== prev_wr)) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.sdram_addr, bus.sdram_data);
        end else begin
          e = exp_q.pop_front();
          check("sdram_addr", 32'(bus.sdram_addr), 32'(e[32:8]));
          check("sdram_data", 32'(bus.sdram_data), 32'(e[7:0]));
        end
      end
      prev_wr = bus.sdram_wr;
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.ioctl_wait) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ioctl_wait_timeout: got wait=1 for 100 cycles expected 0");
    end
  endtask

  task automatic host_wr(input logic [17:0] a, input logic [7:0] d, input bit take);
    wait_ready();
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (take) exp_q.push_back({BASE + 25'(a), d});
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(negedge clk);
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_loaded();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (loaded) break;
    end
  endtask

  task automatic send_image(input int bad);
    logic [7:0] d;
    for (int i = 0; i < 18; i++) begin
      d = (i < 16) ? 8'h55 : ((i == 16) ? 8'h7F : 8'h00);
      if (i == bad) d = 8'h54;
      host_wr(18'(i), d, 1'b1);
    end
  endtask

  initial begin
    int t0;
    int match_cyc;
    int ld_cyc;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;

    // Reset state (ack held at 1 throughout)
    repeat (3) @(negedge clk);
    check("rst_sdram_wr",   32'(bus.sdram_wr),   32'h0);
    check("rst_sdram_addr", 32'(bus.sdram_addr), 32'(BASE));
    check("rst_sdram_data", 32'(bus.sdram_data), 32'h0);
    check("rst_end_addr",   32'(end_addr),       32'h0);
    check("rst_loaded",     32'(loaded),         32'h0);
    check("rst_status",     32'(status),         32'h1);
    check("rst_wait",       32'(bus.ioctl_wait), 32'h1);
    reset_n = 1'b1;
    @(negedge clk);
    check("sync_sdram_wr", 32'(bus.sdram_wr),   32'h1);
    check("idle_wait",     32'(bus.ioctl_wait), 32'h0);
    check("idle_status",   32'(status),         32'h0);
    @(negedge clk);
    mon_en = 1'b1;
    rsp_en = 1'b1;
    repeat (5) @(negedge clk);
    check("no_write_after_sync", 32'(wr_count), 32'h0);

    // Good image
    t0 = wr_count;
    start_dl(8'h01);
    send_image(-1);
    end_dl();
    wait_loaded();
    check("a_toggles",   32'(wr_count - t0), 32'd18);
    check("a_end_addr",  32'(end_addr),      32'd18);
    check("a_header_ok", 32'(status[1]),     32'h1);
    check("a_overrun",   32'(status[2]),     32'h0);
    check("a_loaded",    32'(loaded),        32'h1);

    // Bad lead byte; also check the flags clear on download start
    start_dl(8'h01);
    @(negedge clk);
    check("b_clr_loaded", 32'(loaded),    32'h0);
    check("b_clr_end",    32'(end_addr),  32'h0);
    check("b_clr_hdr",    32'(status[1]), 32'h0);
    send_image(5);
    end_dl();
    wait_loaded();
    check("b_header_ok", 32'(status[1]), 32'h0);
    check("b_loaded",    32'(loaded),    32'h1);
    check("b_end_addr",  32'(end_addr),  32'd18);

    // Overrun: second write while WAIT is held by a slow ack
    ack_delay = 8;
    t0 = wr_count;
    start_dl(8'h01);
    host_wr(18'h0, 8'h55, 1'b1);
    @(negedge clk);
    check("ovr_wait_high", 32'(bus.ioctl_wait), 32'h1);
    bus.ioctl_addr = 18'h1;
    bus.ioctl_dout = 8'h55;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    end_dl();
    repeat (20) @(negedge clk);
    check("ovr_flag",     32'(status[2]),     32'h1);
    check("ovr_loaded",   32'(loaded),        32'h0);
    check("ovr_end_addr", 32'(end_addr),      32'h1);
    check("ovr_toggles",  32'(wr_count - t0), 32'h1);

    // Download ends with the last write unacked for 10 cycles
    ack_delay = 10;
    start_dl(8'h01);
    host_wr(18'h0, 8'h55, 1'b1);
    host_wr(18'h1, 8'h55, 1'b1);
    host_wr(18'h2, 8'h55, 1'b1);
    end_dl();
    match_cyc = -1;
    ld_cyc    = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((match_cyc < 0) && (bus.sdram_ack === bus.sdram_wr)) match_cyc = i;
      if (loaded) begin
        ld_cyc = i;
        break;
      end
    end
    check("flush_loaded_delay", 32'(ld_cyc - match_cyc), 32'h1);
    check("flush_loaded",       32'(loaded),             32'h1);
    check("flush_end_addr",     32'(end_addr),           32'h3);

    // Writes to another index are ignored entirely
    ack_delay = 3;
    t0 = wr_count;
    start_dl(8'h02);
    host_wr(18'h0, 8'h11, 1'b0);
    host_wr(18'h7, 8'h22, 1'b0);
    host_wr(18'h20, 8'h33, 1'b0);
    end_dl();
    repeat (10) @(negedge clk);
    check("idx2_toggles",  32'(wr_count - t0), 32'h0);
    check("idx2_end_addr", 32'(end_addr),      32'h3);
    check("idx2_loaded",   32'(loaded),        32'h1);

    // Start and write in the same cycle, then a write at the top offset
    @(negedge clk);
    bus.ioctl_index    = 8'h01;
    bus.ioctl_download = 1'b1;
    bus.ioctl_addr     = 18'h10;
    bus.ioctl_dout     = 8'h7F;
    bus.ioctl_wr       = 1'b1;
    exp_q.push_back({BASE + 25'h10, 8'h7F});
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("sim_loaded",   32'(loaded),    32'h0);
    check("sim_end_addr", 32'(end_addr),  32'h11);
    check("sim_overrun",  32'(status[2]), 32'h0);
    host_wr(18'h3FFFF, 8'hAA, 1'b1);
    check("sat_end_addr", 32'(end_addr), 32'h3FFFF);
    end_dl();
    wait_loaded();
    check("sat_loaded",    32'(loaded),    32'h1);
    check("sat_header_ok", 32'(status[1]), 32'h0);

    repeat (20) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cas_loader.md
CAS_LOADER -- requirements
Module: cas_loader

Interface
REQ-001 SHALL have parameter CAS_INDEX, default 8'h01, the ioctl_index value that selects a cassette download.
REQ-002 SHALL have parameter BASE_ADDR, default 25'h0, the SDRAM byte address of cassette image byte 0.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ioctl_download  in  1  high while a host download is in progress.
REQ-006 SHALL have port ioctl_index  in  8  download target selector.
REQ-007 SHALL have port ioctl_wr  in  1  one-cycle strobe: ioctl_addr and ioctl_dout are valid.
REQ-008 SHALL have port ioctl_addr  in  18  image byte offset.
REQ-009 SHALL have port ioctl_dout  in  8  image byte.
REQ-010 SHALL have port ioctl_wait  out  1  high means the host must hold off the next ioctl_wr.
REQ-011 SHALL have port sdram_addr  out  25  write address.
REQ-012 SHALL have port sdram_data  out  8  write data.
REQ-013 SHALL have port sdram_wr  out  1  toggle request; a write is pending while sdram_wr != sdram_ack.
REQ-014 SHALL have port sdram_ack  in  1  toggle acknowledge from the SDRAM controller.
REQ-015 SHALL have port end_addr  out  18  image length in bytes, consumed by the cassette player.
REQ-016 SHALL have port loaded  out  1  image complete and valid.
REQ-017 SHALL have port status  out  3  {overrun, header_ok, busy}.

Function
REQ-018 A download is active only while ioctl_download=1 and ioctl_index=CAS_INDEX; while inactive, ioctl_wr SHALL be ignored.
REQ-019 On the rising edge of the active condition, the block SHALL clear end_addr, loaded, header_ok and overrun in that cycle.
REQ-020 The FSM SHALL have states SYNC, IDLE, REQ, WAIT; SYNC is entered after reset; SYNC sets sdram_wr<=sdram_ack and goes to IDLE.
REQ-021 In IDLE, an active ioctl_wr SHALL latch sdram_addr=BASE_ADDR+ioctl_addr and sdram_data=ioctl_dout, then go to REQ.
REQ-022 REQ SHALL toggle sdram_wr and go to WAIT; WAIT SHALL go to IDLE on the first cycle sdram_ack==sdram_wr.
REQ-023 ioctl_wait SHALL be high in SYNC, REQ and WAIT, and also in the IDLE cycle that captures a write; busy SHALL equal ioctl_wait.
REQ-024 An ioctl_wr arriving while not in IDLE SHALL be dropped and SHALL set overrun (sticky until the next download start).
REQ-025 On each accepted write, end_addr SHALL become max(end_addr, ioctl_addr+1), saturating at 18'h3FFFF.
REQ-026 header_ok SHALL be 1 only if image bytes 0x00-0x0F are all 8'h55 and byte 0x10 is 8'h7F.
REQ-027 header_ok SHALL be tracked by a 17-bit match mask, one bit per header offset, each bit set on a matching write to that offset.
REQ-028 loaded SHALL rise on the first cycle after the active condition falls at which the FSM is in IDLE, so the last pending write is flushed first.
REQ-029 loaded SHALL stay low if end_addr=0 or overrun=1.
REQ-030 A download start while a write is pending SHALL NOT abort that write; the flags are still cleared per REQ-019.
REQ-031 A simultaneous download start and ioctl_wr SHALL clear the flags, then apply the write's effects.

Reset
REQ-032 While reset_n=0: FSM=SYNC, sdram_wr=0, sdram_addr=BASE_ADDR, sdram_data=0, end_addr=0, loaded=0, status=3'b001, ioctl_wait=1, header mask=0.
REQ-033 Reset mid-write SHALL abandon that write; the block does not re-issue it.

Structure
REQ-034 Shared package cas_pkg SHALL hold the FSM state encoding, SVI_LEAD_BYTE=8'h55, SVI_SYNC_BYTE=8'h7F and SVI_LEAD_LEN=16.
REQ-035 The header checker SHALL be the single sub-module cas_hdr_check, with inputs clear, wr, addr, data and output ok.

Verification
REQ-036 Reset with sdram_ack=1, then release -> sdram_wr=1 after SYNC, and no write is issued.
REQ-037 Download 18 bytes (16x55, 7F, 00); ack each write after 3 cycles -> 18 toggles, addresses BASE_ADDR+0..17, end_addr=18, header_ok=1, loaded=1.
REQ-038 Same image with byte 5 = 8'h54 -> header_ok=0, loaded=1.
REQ-039 Second ioctl_wr issued while WAIT is held by ack delay -> write dropped, overrun=1, loaded stays 0 after download ends.
REQ-040 Download end while last write is unacked for 10 cycles -> loaded rises exactly one cycle after ack matches; writes with ioctl_index=8'h02 -> no sdram_wr toggles.
